// File: rtl/mult_sequencer.sv
// Unsigned 32x32->64 shift-and-add multiplier that borrows the execute-stage ALU
// for one addition per cycle and writes the product to HI/LO.
module mult_sequencer #(
   parameter logic [2:0] ALU_ADD = 3'b101,
   parameter int         ITER    = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   output logic [2:0]  alu_ctr,
   input  logic [31:0] alu_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [4:0] LAST_COUNT = 5'(ITER - 1);

   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] p_hi_q, p_hi_d;
   logic [31:0] p_lo_q, p_lo_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        carry;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         p_hi_q  <= p_hi_d;
         p_lo_q  <= p_lo_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      p_hi_d   = p_hi_q;
      p_lo_d   = p_lo_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      alu_src1 = '0;
      alu_src2 = '0;
      alu_ctr  = '0;
      carry    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               mcand_d = multiplicand;
               p_hi_d  = '0;
               p_lo_d  = multiplier;
               count_d = '0;
            end
         end
         S_RUN: begin
            alu_ctr  = ALU_ADD;
            alu_src1 = p_hi_q;
            alu_src2 = p_lo_q[0] ? mcand_q : 32'd0;
            // The ALU has no carry-out, so recover bit 32 of the sum from the MSBs.
            carry    = (alu_src1[31] & alu_src2[31]) |
                       ((alu_src1[31] | alu_src2[31]) & ~alu_result[31]);
            p_hi_d   = {carry, alu_result[31:1]};
            p_lo_d   = {alu_result[0], p_lo_q[31:1]};
            count_d  = count_q + 5'd1;
            if (count_q == LAST_COUNT) begin
               state_d = S_DONE;
               hi_d    = p_hi_d;
               lo_d    = p_lo_d;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
